hsst_rx_video_unpack: RTL and testbench
=======================================

# hsst_rx_video_unpack

Upstream stage of the HSST receive path that turns the 16-bit HSST RX word stream (8b/10b decoded, K-flags per byte) into pixel words for the HSST-to-DDR async FIFO write port. It recognises frame and line control words, strips idle and control characters, and writes exactly `LINE_PIXELS` words per accepted line. It drops whole lines when the FIFO is near full, and counts drops and protocol errors. It runs entirely in the HSST RX user clock domain; the FIFO performs the crossing to the DDR side.

## Interface
- `DATA_WIDTH`, 16, pixel/RX word width; fixed to the FIFO write width.
- `LINE_PIXELS`, 1280, data words per line; legal range 2..65535.
- `FRAME_LINES`, 720, lines per frame; legal range 1..4095.
- `clk` in 1: HSST RX user clock, which is also the FIFO `wr_clk`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: lane aligned, word valid; words with `rx_valid`=0 are ignored entirely.
- `rx_data` in 16: RX word.
- `rx_k` in 2: K flag per byte; bit 0 applies to `rx_data[7:0]`.
- `fifo_wr_en` out 1: FIFO write enable.
- `fifo_wr_data` out 16: FIFO write data.
- `fifo_almost_full` in 1: FIFO almost_full, asserted at a fill of 1020.
- `fifo_full` in 1: FIFO wr_full.
- `frame_start` out 1: one-cycle pulse when an SOF is accepted.
- `frame_done` out 1: one-cycle pulse coincident with the last pixel write of line `FRAME_LINES-1`.
- `line_idx` out 12: index of the current or last line.
- `drop_cnt` out 16: count of dropped lines; saturates at 16'hFFFF.
- `err_cnt` out 16: count of protocol errors and overflows; saturates at 16'hFFFF.

## Operation
- Control word decoding: `rx_k`=2'b01 and `rx_data[7:0]`=8'hBC.
  - `rx_data[15:8]`=8'h50 is IDLE.
  - 8'hF0 is SOF.
  - 8'hF1 is SOL.
  - Any other upper byte, or `rx_k` of 2'b10 or 2'b11, is BADK.
- Data word: `rx_k`=2'b00.
- IDLE words are ignored in every state.
- States:
  - IDLE (waiting for SOF)
  - WAIT_SOL
  - LINE
  - DROP
- IDLE:
  - SOF: `line_idx`←0, pulse `frame_start`, then go to LINE, or to DROP if `fifo_almost_full`=1.
  - Data word or SOL: `err_cnt`++, stay in IDLE.
- WAIT_SOL:
  - SOL: `line_idx`++, then go to LINE or DROP using the same `fifo_almost_full` test as above.
  - SOF: incomplete frame. `err_cnt`++, then handle exactly as SOF in IDLE.
  - Data word: `err_cnt`++.
- LINE:
  - Each data word is written to the FIFO and `pix_cnt`++.
  - After write number `LINE_PIXELS`:
    - If `line_idx`=`FRAME_LINES-1`: pulse `frame_done`, go to IDLE.
    - Otherwise go to WAIT_SOL.
  - SOL or SOF arriving early: short line. `err_cnt`++, words already written stay in the FIFO, and the SOL/SOF is then processed as in WAIT_SOL.
- DROP:
  - Data words are discarded and `pix_cnt` counts them.
  - On entry to DROP: `drop_cnt`++.
  - The exit rules are identical to LINE, but `frame_done` still pulses.
- BADK in any state: `err_cnt`++, go to IDLE.
- Data word in LINE while `fifo_full`=1: the word is not written (`fifo_wr_en` stays 0), `err_cnt`++, and `pix_cnt` still advances.
- `pix_cnt` clears on every SOF or SOL.
- The `fifo_almost_full` test is made only at line start; it is never re-evaluated mid-line.
- When two counter increments occur in the same cycle, the counter increments once.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `pix_cnt` 0.
- Latency: the word is sampled at edge N; `fifo_wr_en` and `fifo_wr_data` are registered and valid in cycle N+1.
- `frame_start`, `frame_done`, `line_idx` and the counters are registered with the same 1-cycle latency as the write.
- There is no backpressure to the RX side; one word is accepted every cycle.
- Asserting `rst_n` mid-line abandons the line immediately; the FIFO is reset separately.

## Structure
- Package `hsst_video_pkg` holds:
  - the K28.5 code 8'hBC;
  - the IDLE/SOF/SOL upper bytes;
  - the state enum;
  - the counter width constants.
- Sub-module `hsst_kchar_decode` is combinational: from {`rx_valid`, `rx_k`, `rx_data`} it produces one-hot {idle, sof, sol, badk, data}.
- FSM, counters and output registers live in the top level.

## Test plan
Bench parameters: `LINE_PIXELS`=4, `FRAME_LINES`=2.
- **Nominal frame:** SOF, data 1..4, IDLE, SOL, data 5..8.
  - Expect 8 writes 1..8 in order, each 1 cycle after input.
  - `frame_start` once; `frame_done` on the write of 8.
  - `err_cnt`=0.
- **Idle interleave and rx_valid gaps:** IDLE words and `rx_valid`=0 cycles inside a line.
  - Same 8 writes, no errors.
- **Almost-full drop:** `fifo_almost_full`=1 at SOL of line 1.
  - Line 0 written; line 1 gets no writes.
  - `drop_cnt`=1; `frame_done` still pulses.
- **Short line:** SOF, data 1..2, SOL, data 3..6.
  - Writes 1,2,3,4,5,6; `err_cnt`=1; `line_idx`=1; `frame_done` after 6.
- **BADK mid-line:** SOF, data 1, `rx_k`=2'b11, data 2.
  - Only 1 written; `err_cnt`=2 (BADK, then the data word arriving in IDLE); state IDLE.
- **Full overflow and reset:**
  - `fifo_full` on the 3rd pixel: 3 writes and `err_cnt`=1.
  - Then `rst_n` low mid-line: all outputs 0, and the next SOF starts a clean frame.

Source files
------------

// File: rtl/hsst_video_pkg.sv
// Shared constants, types and helpers for the HSST RX video unpack path.
// K28.5-based control word codes, FSM states and counter widths.
package hsst_video_pkg;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic [7:0] IDLE_B = 8'h50;
  localparam logic [7:0] SOF_B  = 8'hF0;
  localparam logic [7:0] SOL_B  = 8'hF1;

  localparam int PIX_CNT_W  = 16;
  localparam int LINE_IDX_W = 12;
  localparam int STAT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOL = 2'd1,
    ST_LINE     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  typedef struct packed {
    logic idle;
    logic sof;
    logic sol;
    logic badk;
    logic data;
  } kword_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    if (v == {STAT_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(STAT_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/hsst_kchar_decode.sv
// Combinational classifier of one HSST RX word into a one-hot word kind.
// Invalid words classify as nothing at all.
module hsst_kchar_decode
  import hsst_video_pkg::*;
(
  input  logic        rx_valid,
  input  logic [1:0]  rx_k,
  input  logic [15:0] rx_data,
  output kword_t      kword
);

  // Classify the word; any K pattern other than a known K28.5 control word is BADK.
  always_comb begin
    kword = '0;
    if (!rx_valid) begin
      kword = '0;
    end else begin
      case (rx_k)
        2'b00: kword.data = 1'b1;
        2'b01: begin
          if (rx_data[7:0] == K28_5) begin
            case (rx_data[15:8])
              IDLE_B:  kword.idle = 1'b1;
              SOF_B:   kword.sof  = 1'b1;
              SOL_B:   kword.sol  = 1'b1;
              default: kword.badk = 1'b1;
            endcase
          end else begin
            kword.badk = 1'b1;
          end
        end
        default: kword.badk = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/hsst_rx_video_unpack.sv
// Turns the HSST RX word stream into fixed-length pixel lines for the DDR FIFO.
// Whole lines are dropped when the FIFO is near full at line start.
module hsst_rx_video_unpack
  import hsst_video_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LINE_PIXELS = 1280,
  parameter int FRAME_LINES = 720
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [1:0]            rx_k,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_almost_full,
  input  logic                  fifo_full,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [LINE_IDX_W-1:0] line_idx,
  output logic [STAT_CNT_W-1:0] drop_cnt,
  output logic [STAT_CNT_W-1:0] err_cnt
);

  localparam logic [PIX_CNT_W-1:0]  LAST_PIX  = PIX_CNT_W'(LINE_PIXELS - 1);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(FRAME_LINES - 1);

  kword_t                 kword_s;
  state_t                 state_r;
  logic [PIX_CNT_W-1:0]   pix_cnt_r;
  logic                   err_inc_s;
  logic                   in_line_s;

  hsst_kchar_decode u_decode (
    .rx_valid (rx_valid),
    .rx_k     (rx_k),
    .rx_data  (rx_data),
    .kword    (kword_s)
  );

  assign in_line_s = (state_r == ST_LINE) || (state_r == ST_DROP);

  // Merge every error source of this cycle into a single increment request.
  always_comb begin
    err_inc_s = 1'b0;
    if (kword_s.idle) begin
      err_inc_s = 1'b0;
    end else if (kword_s.badk) begin
      err_inc_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE:     err_inc_s = kword_s.data || kword_s.sol;
        ST_WAIT_SOL: err_inc_s = kword_s.data || kword_s.sof;
        ST_LINE:     err_inc_s = kword_s.sof || kword_s.sol || (kword_s.data && fifo_full);
        ST_DROP:     err_inc_s = kword_s.sof || kword_s.sol;
        default:     err_inc_s = 1'b0;
      endcase
    end
  end

  // Line FSM, pixel counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pix_cnt_r    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      line_idx     <= '0;
      drop_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      fifo_wr_en  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (err_inc_s) begin
        err_cnt <= sat_inc(err_cnt);
      end
      if (kword_s.badk) begin
        state_r <= ST_IDLE;
      end else if (kword_s.sof || (kword_s.sol && state_r != ST_IDLE)) begin
        // Line start: the only point where almost_full is sampled.
        pix_cnt_r <= '0;
        if (kword_s.sof) begin
          line_idx    <= '0;
          frame_start <= 1'b1;
        end else begin
          line_idx <= line_idx + 12'd1;
        end
        if (fifo_almost_full) begin
          state_r  <= ST_DROP;
          drop_cnt <= sat_inc(drop_cnt);
        end else begin
          state_r <= ST_LINE;
        end
      end else if (kword_s.data && in_line_s) begin
        if (state_r == ST_LINE && !fifo_full) begin
          fifo_wr_en   <= 1'b1;
          fifo_wr_data <= rx_data;
        end
        pix_cnt_r <= pix_cnt_r + 16'd1;
        if (pix_cnt_r == LAST_PIX) begin
          if (line_idx == LAST_LINE) begin
            frame_done <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_SOL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hsst_rx_video_unpack.sv
// Directed bench for hsst_rx_video_unpack with 4-pixel lines and 2-line frames.
module tb_hsst_rx_video_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic [1:0]  rx_k = 2'b00;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        frame_start;
  logic        frame_done;
  logic [11:0] line_idx;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  localparam logic [7:0] B_IDLE = 8'h50;
  localparam logic [7:0] B_SOF  = 8'hF0;
  localparam logic [7:0] B_SOL  = 8'hF1;

  always #5 clk = ~clk;

  hsst_rx_video_unpack #(
    .DATA_WIDTH  (16),
    .LINE_PIXELS (4),
    .FRAME_LINES (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_k             (rx_k),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .frame_start      (frame_start),
    .frame_done       (frame_done),
    .line_idx         (line_idx),
    .drop_cnt         (drop_cnt),
    .err_cnt          (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one word, let the DUT sample it, then check the registered outputs.
  task automatic step(input logic v, input logic [1:0] k, input logic [15:0] d,
                      input logic ewe, input logic efs, input logic efd, input string tag);
    rx_valid = v;
    rx_k     = k;
    rx_data  = d;
    @(posedge clk);
    #1;
    chk({tag, ".wr_en"}, {31'd0, fifo_wr_en}, {31'd0, ewe});
    if (ewe) chk({tag, ".wr_data"}, {16'd0, fifo_wr_data}, {16'd0, d});
    chk({tag, ".frame_start"}, {31'd0, frame_start}, {31'd0, efs});
    chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, efd});
  endtask

  task automatic ctl(input logic [7:0] ub, input string tag);
    step(1'b1, 2'b01, {ub, 8'hBC}, 1'b0, (ub == B_SOF), 1'b0, tag);
  endtask

  task automatic pix(input logic [15:0] d, input logic ewe, input logic efd, input string tag);
    step(1'b1, 2'b00, d, ewe, 1'b0, efd, tag);
  endtask

  task automatic gap(input string tag);
    step(1'b0, 2'b00, 16'hDEAD, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".wr_en"}, {31'd0, fifo_wr_en}, 32'd0);
    chk({tag, ".wr_data"}, {16'd0, fifo_wr_data}, 32'd0);
    chk({tag, ".frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, ".frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, ".line_idx"}, {20'd0, line_idx}, 32'd0);
    chk({tag, ".drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
    chk({tag, ".err_cnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic stats(input string tag, input logic [11:0] eli, input logic [15:0] edr,
                       input logic [15:0] eer);
    chk({tag, ".line_idx"}, {20'd0, line_idx}, {20'd0, eli});
    chk({tag, ".drop_cnt"}, {16'd0, drop_cnt}, {16'd0, edr});
    chk({tag, ".err_cnt"}, {16'd0, err_cnt}, {16'd0, eer});
  endtask

  initial begin
    #2;
    check_zero("reset");
    do_reset();

    // Nominal frame
    ctl(B_SOF, "nom.sof");
    for (int i = 1; i <= 4; i++) pix(16'(i), 1'b1, 1'b0, "nom.l0");
    ctl(B_IDLE, "nom.idle");
    ctl(B_SOL, "nom.sol");
    for (int i = 5; i <= 8; i++) pix(16'(i), 1'b1, (i == 8), "nom.l1");
    stats("nom", 12'd1, 16'd0, 16'd0);

    // Idle words and rx_valid gaps inside lines
    do_reset();
    ctl(B_SOF, "gap.sof");
    pix(16'd1, 1'b1, 1'b0, "gap.p1");
    ctl(B_IDLE, "gap.i1");
    gap("gap.g1");
    pix(16'd2, 1'b1, 1'b0, "gap.p2");
    pix(16'd3, 1'b1, 1'b0, "gap.p3");
    gap("gap.g2");
    gap("gap.g3");
    pix(16'd4, 1'b1, 1'b0, "gap.p4");
    ctl(B_IDLE, "gap.i2");
    ctl(B_SOL, "gap.sol");
    pix(16'd5, 1'b1, 1'b0, "gap.p5");
    ctl(B_IDLE, "gap.i3");
    pix(16'd6, 1'b1, 1'b0, "gap.p6");
    gap("gap.g4");
    pix(16'd7, 1'b1, 1'b0, "gap.p7");
    pix(16'd8, 1'b1, 1'b1, "gap.p8");
    stats("gap", 12'd1, 16'd0, 16'd0);

    // Almost-full at the start of line 1 drops that line
    do_reset();
    ctl(B_SOF, "drop.sof");
    for (int i = 1; i <= 4; i++) pix(16'(i), 1'b1, 1'b0, "drop.l0");
    fifo_almost_full = 1'b1;
    ctl(B_SOL, "drop.sol");
    fifo_almost_full = 1'b0;
    stats("drop.entry", 12'd1, 16'd1, 16'd0);
    for (int i = 5; i <= 8; i++) pix(16'(i), 1'b0, (i == 8), "drop.l1");
    stats("drop", 12'd1, 16'd1, 16'd0);

    // Short line 0
    do_reset();
    ctl(B_SOF, "short.sof");
    pix(16'd1, 1'b1, 1'b0, "short.p1");
    pix(16'd2, 1'b1, 1'b0, "short.p2");
    ctl(B_SOL, "short.sol");
    for (int i = 3; i <= 6; i++) pix(16'(i), 1'b1, (i == 6), "short.l1");
    stats("short", 12'd1, 16'd0, 16'd1);

    // BADK mid-line aborts to IDLE
    do_reset();
    ctl(B_SOF, "badk.sof");
    pix(16'd1, 1'b1, 1'b0, "badk.p1");
    step(1'b1, 2'b11, 16'hBCBC, 1'b0, 1'b0, 1'b0, "badk.k");
    pix(16'd2, 1'b0, 1'b0, "badk.p2");
    stats("badk", 12'd0, 16'd0, 16'd2);

    // FIFO full on the third pixel, then reset mid-line
    do_reset();
    ctl(B_SOF, "full.sof");
    pix(16'd1, 1'b1, 1'b0, "full.p1");
    pix(16'd2, 1'b1, 1'b0, "full.p2");
    fifo_full = 1'b1;
    pix(16'd3, 1'b0, 1'b0, "full.p3");
    fifo_full = 1'b0;
    pix(16'd4, 1'b1, 1'b0, "full.p4");
    stats("full", 12'd0, 16'd0, 16'd1);
    ctl(B_SOL, "full.sol");
    pix(16'd5, 1'b1, 1'b0, "full.p5");
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ctl(B_SOF, "clean.sof");
    for (int i = 1; i <= 4; i++) pix(16'(i + 16), 1'b1, 1'b0, "clean.l0");
    stats("clean", 12'd0, 16'd0, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
